// File: rtl/uart_rx_axis_pkg.sv
// uart_rx_axis_pkg
//   Shared definitions for the UART receive path: receiver FSM state
//   encodings and the default line settings (16 MHz clock, 57600 baud,
//   newline as end-of-line marker, 4-entry receive FIFO).
//   No ports; imported by uart_rx_axis.
package uart_rx_axis_pkg;

  // 16 MHz / 57600 baud, rounded to the nearest whole cycle count
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 278;
  localparam logic [7:0]  DEFAULT_EOL_BYTE     = 8'h0A;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 4;

  // Receiver FSM encodings, kept as plain constants so older tools and
  // waveform viewers that only understand vectors can still decode them
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/axis_byte_fifo.sv
// axis_byte_fifo
//   Small byte FIFO with an AXI-Stream style read side. It absorbs short
//   consumer stalls so received bytes are not lost. A push into a full FIFO
//   still succeeds if the head is popped in the same cycle; otherwise the
//   byte is dropped and overrun_o pulses for one cycle.
// Ports
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   push_i      write request, one cycle per byte
//   pushData_i  byte to write
//   tready_i    consumer ready; pop happens on tvalid_o & tready_i
//   tdata_o     byte at the FIFO head
//   tvalid_o    FIFO not empty
//   overrun_o   one-cycle pulse when a pushed byte was dropped
module axis_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] pushData_i,
  input  logic       tready_i,
  output logic [7:0] tdata_o,
  output logic       tvalid_o,
  output logic       overrun_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic isEmpty;
  logic isFull;
  logic pop;
  logic pushOk;

  // A pop frees the head slot in the same edge the write lands, so a full
  // FIFO can accept a byte exactly when the consumer takes one. Pointers
  // are AW bits wide and DEPTH is a power of two, so they wrap on their own.
  always_comb begin
    isEmpty   = (count_q == '0);
    isFull    = (count_q == FULL_COUNT);
    pop       = !isEmpty && tready_i;
    pushOk    = push_i && (!isFull || pop);
    overrun_d = push_i && isFull && !pop;

    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({pushOk, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= pushData_i;
      end
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign tdata_o   = mem_q[rdPtr_q];
  assign tvalid_o  = !isEmpty;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis
//   8N1 UART receiver presenting received bytes as an AXI-Stream byte
//   stream. The serial line is synchronised, sampled mid-bit by a down-
//   counting bit timer, and completed bytes are pushed into a small skid
//   FIFO. o_tlast flags the end-of-line byte.
// Ports
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_uart_rx    serial input, idle high, asynchronous to i_clk
//   o_tdata      byte at the FIFO head
//   o_tlast      head byte equals EOL_BYTE (qualified by o_tvalid)
//   o_tvalid     FIFO not empty
//   i_tready     consumer ready
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte dropped because the FIFO was full
module uart_rx_axis
  import uart_rx_axis_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0]  EOL_BYTE     = DEFAULT_EOL_BYTE,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q;
  logic          rxS;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] bitTimer_q, bitTimer_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frameErr_q, frameErr_d;
  logic          pushByte;
  logic [7:0]    fifoData;
  logic          fifoValid;

  // Two-flop synchroniser; both stages reset to the idle (high) line level
  // so a reset never looks like a start bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rxS = sync2_q;

  // Receiver FSM. The first wait is half a bit so every later sample falls
  // mid-bit. A low stop bit leads to BREAK, which waits for the line to go
  // high so a held-low line cannot retrigger endless frames.
  always_comb begin
    state_d    = state_q;
    bitTimer_d = bitTimer_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    frameErr_d = 1'b0;
    pushByte   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxS) begin
          state_d    = ST_START;
          bitTimer_d = HALF_RELOAD;
        end
      end

      ST_START: begin
        if (bitTimer_q == '0) begin
          bitTimer_d = FULL_RELOAD;
          if (!rxS) begin
            state_d  = ST_DATA;
            bitIdx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bitTimer_d = bitTimer_q - TW'(1);
        end
      end

      ST_DATA: begin
        if (bitTimer_q == '0) begin
          shift_d    = {rxS, shift_q[7:1]};
          bitTimer_d = FULL_RELOAD;
          if (bitIdx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          bitTimer_d = bitTimer_q - TW'(1);
        end
      end

      ST_STOP: begin
        if (bitTimer_q == '0) begin
          bitTimer_d = FULL_RELOAD;
          if (rxS) begin
            pushByte = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          bitTimer_d = bitTimer_q - TW'(1);
        end
      end

      ST_BREAK: begin
        if (rxS) begin
          state_d    = ST_IDLE;
          bitTimer_d = FULL_RELOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, timer, bit counter, shift register and the frame-error pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bitTimer_q <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitTimer_q <= bitTimer_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
    end
  end

  // The push uses shift_q, which already holds all eight data bits once the
  // FSM is in STOP
  axis_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (pushByte),
    .pushData_i (shift_q),
    .tready_i   (i_tready),
    .tdata_o    (fifoData),
    .tvalid_o   (fifoValid),
    .overrun_o  (o_overrun)
  );

  assign o_tdata     = fifoData;
  assign o_tvalid    = fifoValid;
  assign o_tlast     = fifoValid && (fifoData == EOL_BYTE);
  assign o_frame_err = frameErr_q;

endmodule
